mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 88 ++++++++
 tb/tb_mem_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a handshaked data-memory access FSM, write-back feed and forwarding.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush,
    input  logic [6:0]  WB_in,
    input  logic [1:0]  M_in,
    input  logic [15:0] PCret_in,
    input  logic [15:0] ALU_in,
    input  logic [15:0] StoreData_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [6:0]  WB_out,
    output logic [15:0] PCret_out,
    output logic [15:0] ALU_out,
    output logic [15:0] MemData_out,
    output logic        mem_busy,
    output logic        fwd_regwrite,
    output logic [3:0]  fwd_addr,
    output logic [15:0] fwd_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_n;
    logic [6:0] WB_r, wb_ld;
    logic [1:0] M_r, m_ld;
    logic [15:0] PC_r, ALU_r, SD_r, MD_r;
    logic sent, advance, wb_live;
    always_comb begin
        advance = !stall_in && !mem_busy;
        wb_ld = flush ? 7'h0 : WB_in;
        m_ld = flush ? 2'b0 : M_in;
        state_n = state;
        if (advance)
            state_n = |m_ld ? ACCESS : IDLE;
        else if (state == ACCESS && mem_ready)
            state_n = DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_r <= '0;
            M_r <= '0;
            PC_r <= '0;
            ALU_r <= '0;
            SD_r <= '0;
            MD_r <= '0;
            sent <= 1'b0;
        end else if (advance) begin
            WB_r <= wb_ld;
            M_r <= m_ld;
            PC_r <= PCret_in;
            ALU_r <= ALU_in;
            SD_r <= StoreData_in;
            sent <= 1'b0;
        end else begin
            if (state == ACCESS && mem_ready && M_r[0])
                MD_r <= mem_rdata;
            // a held instruction reaches write-back only once
            if (wb_live)
                sent <= 1'b1;
        end
    end
    always_comb begin
        mem_busy = state == ACCESS;
        mem_req = mem_busy;
        mem_we = mem_busy && M_r[1];
        mem_addr = ALU_r;
        mem_wdata = SD_r;
        wb_live = !mem_busy && !sent && |WB_r;
        WB_out = (!mem_busy && !sent) ? WB_r : 7'h0;
        PCret_out = PC_r;
        ALU_out = ALU_r;
        MemData_out = MD_r;
        fwd_regwrite = |WB_r && WB_r[2];
        fwd_addr = |WB_r ? WB_r[6:3] : 4'h0;
        fwd_data = |WB_r ? ALU_r : 16'h0;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
module tb_mem_stage;
    logic clk = 0, rst = 1, stall_in = 0, flush = 0, mem_ready = 0;
    logic [6:0] WB_in = 0;
    logic [1:0] M_in = 0;
    logic [15:0] PCret_in = 0, ALU_in = 0, StoreData_in = 0, mem_rdata = 0;
    logic mem_req, mem_we, mem_busy, fwd_regwrite;
    logic [15:0] mem_addr, mem_wdata, PCret_out, ALU_out, MemData_out, fwd_data;
    logic [6:0] WB_out;
    logic [3:0] fwd_addr;
    int vectors = 0, miscompares = 0;

    typedef struct packed {
        logic req, we, busy;
        logic [6:0] wb;
        logic [15:0] addr, wdata, alu, md, pc;
        logic fw;
        logic [3:0] fa;
        logic [15:0] fd;
    } obs_t;
    obs_t eq[$];
    string tq[$];

    mem_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .WB_in(WB_in), .M_in(M_in), .PCret_in(PCret_in), .ALU_in(ALU_in),
        .StoreData_in(StoreData_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .WB_out(WB_out), .PCret_out(PCret_out),
        .ALU_out(ALU_out), .MemData_out(MemData_out), .mem_busy(mem_busy),
        .fwd_regwrite(fwd_regwrite), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic req, we, busy, logic [6:0] wb,
                                logic [15:0] addr, wdata, md, pc,
                                logic fw, logic [3:0] fa, logic [15:0] fd);
        return {req, we, busy, wb, addr, wdata, addr, md, pc, fw, fa, fd};
    endfunction

    task automatic push(string t, obs_t e);
        tq.push_back(t);
        eq.push_back(e);
    endtask

    task automatic check();
        obs_t o, e;
        string t;
        vectors++;
        o = {mem_req, mem_we, mem_busy, WB_out, mem_addr, mem_wdata, ALU_out,
             MemData_out, PCret_out, fwd_regwrite, fwd_addr, fwd_data};
        if (eq.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required an entry", o);
        end else begin
            e = eq.pop_front();
            t = tq.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h required %h", t, o, e);
            end
        end
    endtask

    task automatic drive(logic [6:0] wb, logic [1:0] m, logic [15:0] pc, alu, sd);
        WB_in = wb;
        M_in = m;
        PCret_in = pc;
        ALU_in = alu;
        StoreData_in = sd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        push("reset", mk(0,0,0,7'h00,16'h0,16'h0,16'h0,16'h0,0,4'h0,16'h0));
        check();
        cyc();
        rst = 0;
        // ALU pass-through
        drive(7'h2C, 2'b00, 16'h0100, 16'h1234, 16'h0);
        push("alu_pass", mk(0,0,0,7'h2C,16'h1234,16'h0,16'h0,16'h0100,1,4'h5,16'h1234));
        cyc(); check();
        drive(7'h00, 2'b00, 16'h0, 16'h0, 16'h0);
        push("bubble", mk(0,0,0,7'h00,16'h0,16'h0,16'h0,16'h0,0,4'h0,16'h0));
        cyc(); check();
        // three-cycle load
        drive(7'h25, 2'b01, 16'h0200, 16'h0040, 16'h0);
        push("load_c1", mk(1,0,1,7'h00,16'h0040,16'h0,16'h0,16'h0200,1,4'h4,16'h0040));
        cyc(); check();
        drive(7'h00, 2'b00, 16'h0, 16'h0, 16'h0);
        push("load_c2", mk(1,0,1,7'h00,16'h0040,16'h0,16'h0,16'h0200,1,4'h4,16'h0040));
        cyc(); check();
        push("load_c3", mk(1,0,1,7'h00,16'h0040,16'h0,16'h0,16'h0200,1,4'h4,16'h0040));
        cyc(); check();
        mem_ready = 1;
        mem_rdata = 16'hBEEF;
        push("load_done", mk(0,0,0,7'h25,16'h0040,16'h0,16'hBEEF,16'h0200,1,4'h4,16'h0040));
        cyc(); check();
        mem_ready = 0;
        mem_rdata = 16'h0;
        push("load_once", mk(0,0,0,7'h00,16'h0,16'h0,16'hBEEF,16'h0,0,4'h0,16'h0));
        cyc(); check();
        // store with immediate ready
        drive(7'h00, 2'b10, 16'h0300, 16'h0010, 16'hA5A5);
        mem_ready = 1;
        push("store_req", mk(1,1,1,7'h00,16'h0010,16'hA5A5,16'hBEEF,16'h0300,0,4'h0,16'h0));
        cyc(); check();
        drive(7'h00, 2'b00, 16'h0, 16'h0, 16'h0);
        push("store_done", mk(0,0,0,7'h00,16'h0010,16'hA5A5,16'hBEEF,16'h0300,0,4'h0,16'h0));
        cyc(); check();
        mem_ready = 0;
        push("store_next", mk(0,0,0,7'h00,16'h0,16'h0,16'hBEEF,16'h0,0,4'h0,16'h0));
        cyc(); check();
        // flush turns a load into a bubble
        drive(7'h25, 2'b01, 16'h0400, 16'h0050, 16'h0);
        flush = 1;
        push("flush", mk(0,0,0,7'h00,16'h0050,16'h0,16'hBEEF,16'h0400,0,4'h0,16'h0));
        cyc(); check();
        flush = 0;
        // stall after a RegWrite instruction
        drive(7'h2C, 2'b00, 16'h0500, 16'h0077, 16'h0);
        push("stall_first", mk(0,0,0,7'h2C,16'h0077,16'h0,16'hBEEF,16'h0500,1,4'h5,16'h0077));
        cyc(); check();
        stall_in = 1;
        drive(7'h3C, 2'b00, 16'h0600, 16'h9999, 16'h0);
        for (int i = 0; i < 3; i++) begin
            push($sformatf("stall_hold%0d", i),
                 mk(0,0,0,7'h00,16'h0077,16'h0,16'hBEEF,16'h0500,1,4'h5,16'h0077));
            cyc(); check();
        end
        stall_in = 0;
        push("stall_resume", mk(0,0,0,7'h3C,16'h9999,16'h0,16'hBEEF,16'h0600,1,4'h7,16'h9999));
        cyc(); check();
        // reset in the middle of an access
        drive(7'h25, 2'b01, 16'h0700, 16'h0080, 16'h0);
        push("rst_pre", mk(1,0,1,7'h00,16'h0080,16'h0,16'hBEEF,16'h0700,1,4'h4,16'h0080));
        cyc(); check();
        stall_in = 1;
        drive(7'h00, 2'b00, 16'h0, 16'h0, 16'h0);
        #2 rst = 1;
        #1;
        push("rst_async", mk(0,0,0,7'h00,16'h0,16'h0,16'h0,16'h0,0,4'h0,16'h0));
        check();
        #1 rst = 0;
        stall_in = 0;
        mem_ready = 1;
        mem_rdata = 16'h5555;
        push("rst_after", mk(0,0,0,7'h00,16'h0,16'h0,16'h0,16'h0,0,4'h0,16'h0));
        cyc(); check();
        mem_ready = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
